// File: rtl/johnson_counter_param.sv
// ----------------------------------------------------------------------------
// johnson_counter_param
//
// Parametrised Johnson / ring counter used as a multi-phase sequencer and
// strobe generator. The shift register steps up (shift left) or down (shift
// right) under a count enable, can be parallel-loaded, self-corrects states
// that are not legal for the selected mode, and exposes a binary phase index
// plus a one-cycle wrap pulse for downstream control.
//
// Parameters
//   WIDTH    : number of flip-flops in the shift register (2..32)
//   PW       : width of the phase index, derived from WIDTH (do not override)
//
// Ports
//   clk      : in  system clock, all state updates on the rising edge
//   rst      : in  synchronous active-high reset
//   en       : in  count enable, one step per clock when high
//   dir      : in  0 = up (shift left), 1 = down (shift right)
//   mode     : in  0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH)
//   load     : in  synchronous parallel load strobe (overrides en)
//   load_val : in  value written to q on load, accepted verbatim
//   q        : out registered counter state
//   phase    : out binary phase index decoded from q and mode (0 if illegal)
//   wrap     : out registered pulse on a sequence boundary crossing
//   illegal  : out high while q is not a legal state for the current mode
// ----------------------------------------------------------------------------
module johnson_counter_param #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [PW-1:0] LAST_JOHNSON = PW'(2 * WIDTH - 1);
  localparam logic [PW-1:0] LAST_RING    = PW'(WIDTH - 1);

  // Mask with the low k bits set (k = 0..WIDTH).
  function automatic logic [WIDTH-1:0] low_mask(input int k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < k) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Johnson legal states: low k ones (phase k) or high j ones (phase 2W-j).
  function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (v == low_mask(k)) ok = 1'b1;
    end
    for (int j = 1; j < WIDTH; j++) begin
      if (v == ~low_mask(WIDTH - j)) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [PW-1:0] johnson_phase(input logic [WIDTH-1:0] v);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (v == low_mask(k)) p = PW'(k);
    end
    for (int j = 1; j < WIDTH; j++) begin
      if (v == ~low_mask(WIDTH - j)) p = PW'(2 * WIDTH - j);
    end
    return p;
  endfunction

  // Ring legal states are one-hot; the phase is the index of the set bit.
  function automatic logic ring_legal(input logic [WIDTH-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt == 1);
  endfunction

  function automatic logic [PW-1:0] ring_phase(input logic [WIDTH-1:0] v);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) p = PW'(i);
    end
    return p;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  logic             legal;
  logic [PW-1:0]    phase_cur;
  logic [PW-1:0]    last_phase;
  logic [WIDTH-1:0] step_val;

  // Decode of the current state under the current mode.
  always_comb begin
    legal      = mode ? ring_legal(q_q) : johnson_legal(q_q);
    last_phase = mode ? LAST_RING : LAST_JOHNSON;
    phase_cur  = '0;
    if (legal) begin
      phase_cur = mode ? ring_phase(q_q) : johnson_phase(q_q);
    end
  end

  // Next value for a legal enabled step; Johnson inverts the bit fed back,
  // ring feeds it back unchanged.
  always_comb begin
    step_val = q_q;
    if (!dir) begin
      step_val = {q_q[WIDTH-2:0], (mode ? q_q[WIDTH-1] : ~q_q[WIDTH-1])};
    end else begin
      step_val = {(mode ? q_q[0] : ~q_q[0]), q_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (!legal) begin
        // Correction step lands on phase 0 of the current mode, no wrap.
        q_d = mode ? WIDTH'(1) : '0;
      end else begin
        q_d    = step_val;
        wrap_d = dir ? (phase_cur == '0) : (phase_cur == last_phase);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q       = q_q;
  assign wrap    = wrap_q;
  assign phase   = phase_cur;
  assign illegal = ~legal;

endmodule

// File: tb/tb_johnson_counter_param.sv
module tb_johnson_counter_param;

  localparam int W  = 8;
  localparam int PW = $clog2(2 * W);

  logic          clk;
  logic          rst, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap, illegal;

  johnson_counter_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .phase(phase), .wrap(wrap), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [PW-1:0] ph;
    logic          wrap;
    logic          ill;
    logic [31:0]   idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_issued = 0;
  bit   done = 0;

  // Reference model state: raw register contents plus last wrap.
  logic [W-1:0] m_q;
  logic         m_wrap;

  // State sequence table: the register contents for phase p of a mode.
  function automatic logic [W-1:0] seq_state(input bit md, input int p);
    if (md) return W'(1 << p);
    if (p <= W) return W'((1 << p) - 1);
    return W'(((1 << W) - 1) ^ ((1 << (p - W)) - 1));
  endfunction

  // Phase lookup: search the sequence table for the value.
  function automatic void decode(input logic [W-1:0] v, input bit md,
                                 output int ph, output bit leg);
    int per;
    per = md ? W : 2 * W;
    ph  = 0;
    leg = 0;
    for (int i = 0; i < per; i++) begin
      if (seq_state(md, i) == v) begin
        ph  = i;
        leg = 1;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit ld, input logic [W-1:0] lv,
                     input bit e, input bit d, input bit md);
    int   ph, per, np;
    bit   leg;
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; load_val = lv; en = e; dir = d; mode = md;
    if (r) begin
      m_q = '0; m_wrap = 0;
    end else if (ld) begin
      m_q = lv; m_wrap = 0;
    end else if (e) begin
      decode(m_q, md, ph, leg);
      if (!leg) begin
        m_q = md ? W'(1) : '0;
        m_wrap = 0;
      end else begin
        per    = md ? W : 2 * W;
        np     = d ? (ph + per - 1) % per : (ph + 1) % per;
        m_wrap = d ? (ph == 0) : (ph == per - 1);
        m_q    = seq_state(md, np);
      end
    end else begin
      m_wrap = 0;
    end
    decode(m_q, md, ph, leg);
    x.q    = m_q;
    x.ph   = PW'(ph);
    x.wrap = m_wrap;
    x.ill  = !leg;
    x.idx  = n_issued;
    n_issued++;
    sb.push_back(x);
  endtask

  // Monitor: the counter presents a result every clock after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (q !== x.q || phase !== x.ph || wrap !== x.wrap || illegal !== x.ill) begin
          errors++;
          $display("FAIL step%0d: got q=%b phase=%0d wrap=%b illegal=%b, expected q=%b phase=%0d wrap=%b illegal=%b",
                   x.idx, q, phase, wrap, illegal, x.q, x.ph, x.wrap, x.ill);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] lv;
    bit           r, ld, e, d, md;
    rst = 1; load = 0; load_val = '0; en = 0; dir = 0; mode = 0;
    m_q = '0; m_wrap = 0;

    // Johnson up over a full period.
    cyc(1, 0, 0, 0, 0, 0);
    repeat (16) cyc(0, 0, 0, 1, 0, 0);
    // Johnson down from reset.
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 1, 0);
    // Ring mode wrap both directions.
    cyc(0, 1, 8'h04, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 1, 1);
    // Illegal correction in both modes.
    cyc(0, 1, 8'h50, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 8'h00, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    // Priority and hold.
    cyc(1, 1, 8'hAA, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 8'h0F, 1, 0, 0);
    // Mode switch mid-count and reset mid-sequence.
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    repeat (5) cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Randomised traffic.
    md = 0; d = 0;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) d = ~d;
      if ($urandom_range(0, 29) == 0) md = ~md;
      if ($urandom_range(0, 1) == 0)
        lv = W'($urandom);
      else
        lv = seq_state(md, md ? $urandom_range(0, W - 1) : $urandom_range(0, 2 * W - 1));
      cyc(r, ld, lv, e, d, md);
    end

    // Drain the scoreboard within a bounded number of cycles.
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
Parametrised successor to the team's fixed 8-bit Johnson counter, used as a multi-phase sequencer and clock-phase/strobe generator.
- Supports twisted-ring (Johnson) and ring (one-hot) modes.
- Counts up or down, with count enable and parallel load.
- Self-corrects illegal states.
- Provides a binary phase index and a wrap pulse for downstream control logic.

Parameters:
- WIDTH, 8, number of flip-flops in the shift register (legal range 2..32).
- PW, $clog2(2*WIDTH), width of the phase index output (derived; not overridden by instantiators).

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, count enable; advances one step per clk when high.
- dir, input, 1, 0 = up (shift left), 1 = down (shift right).
- mode, input, 1, 0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH).
- load, input, 1, synchronous parallel load strobe.
- load_val, input, WIDTH, value written to q on load.
- q, output, WIDTH, registered counter state.
- phase, output, PW, binary phase index decoded from q (combinational from q and mode).
- wrap, output, 1, registered one-cycle pulse on a sequence boundary crossing.
- illegal, output, 1, high while q is not a legal state for the current mode (combinational).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). Priority at each rising clk edge is rst > load > en.
- Reset: q = 0, wrap = 0, so phase = 0.
  - Johnson mode: illegal = 0.
  - Ring mode: illegal = 1; the first enabled step corrects q to 1.
- Load: q <= load_val verbatim, even if illegal; wrap <= 0. en is ignored in that cycle.
- Hold: en = 0 and no load means q holds and wrap <= 0.
- Johnson mode, legal states (2*WIDTH total):
  - Low k bits set, k = 0..WIDTH: phase = k.
  - High j bits set, j = 1..WIDTH-1: phase = 2*WIDTH - j.
  - Example, WIDTH = 8: 1111_1110 is phase 9; 1000_0000 is phase 15.
- Johnson mode, stepping:
  - Up: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Down: q <= {~q[0], q[WIDTH-1:1]}.
- Ring mode, legal states: exactly one bit set; phase = index of the set bit.
- Ring mode, stepping:
  - Up: rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Down: rotate right, q <= {q[0], q[WIDTH-1:1]}.
- Illegal state:
  - illegal = 1 and phase = 0.
  - On the next enabled step (not load), q is corrected instead of shifted: Johnson to 0, ring to 1 (phase 0). wrap <= 0 on a correction step.
- Wrap:
  - Up step from phase LAST to phase 0 sets wrap <= 1.
  - Down step from phase 0 to phase LAST sets wrap <= 1.
  - LAST = 2*WIDTH-1 (Johnson) or WIDTH-1 (ring).
  - All other cycles set wrap <= 0.
  - wrap is high in the same cycle q shows the new value.
- Mode change mid-count: takes effect on the next edge. q is reinterpreted under the new mode; if illegal there, the next enabled step corrects it. Example: Johnson 0000_0011 switched to ring is illegal, so the next step gives 0000_0001.
- Direction change: takes effect on the next enabled edge, with no dead cycle.
- Reset asserted mid-sequence, or coincident with load/en: reset wins; q = 0 next cycle and wrap = 0.

Test Plan:
- WIDTH = 8, Johnson up: rst for 1 cycle, then en = 1 for 16 cycles. q runs 0000_0001, 0000_0011, … 1111_1111, 1111_1110, … 1000_0000, 0000_0000. phase counts 1..15 then 0. wrap is high only in the cycle q returns to 0. illegal stays 0 throughout.
- Johnson down: from reset, dir = 1, en = 1. q = 1000_0000 (phase 15, wrap = 1), then 1100_0000 (phase 14, wrap = 0).
- Ring mode: mode = 1, load 0000_0100, then en = 1 up for 6 steps. q reaches 1000_0000 (phase 7); the next step gives 0000_0001 with wrap = 1. Then dir = 1: 1000_0000 with wrap = 1.
- Illegal correction: load 0101_0000 in Johnson mode gives illegal = 1, phase = 0. The next en step gives q = 0, illegal = 0, wrap = 0. In ring mode, load 0000_0000, then one step gives q = 0000_0001.
- Priority and hold: drive rst = 1, load = 1, en = 1 together; q = 0. Then en = 0 for 5 cycles; q is unchanged and wrap = 0. Then load = 1 with en = 1 and load_val = 0000_1111; q = 0000_1111 (phase 4), not advanced.
- Mid-sequence reset and mode switch: at Johnson phase 2 (0000_0011), switch to mode = 1; illegal = 1. One step gives 0000_0001. Assert rst at ring phase 5; the next cycle gives q = 0.
